rshift_ctrl: RTL and testbench

RSHIFT_CTRL -- requirements
Module: rshift_ctrl

---
 rtl/attn_ctrl_pkg.sv | 25 ++
 rtl/rshift_ctrl_sideband_delay.sv | 39 +++
 rtl/rshift_ctrl.sv | 171 +++++++++++++++++
 tb/tb_rshift_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/attn_ctrl_pkg.sv
// Shared types for the attention-score rshift controller: FSM states and
// the per-tile sideband that travels alongside the rshift pipeline.
package attn_ctrl_pkg;

  // Default tiling; the sideband field widths are sized from these.
  localparam int unsigned DEF_TILES_ROW  = 4;
  localparam int unsigned DEF_ROW_BLOCKS = 2;
  localparam int unsigned SB_COL_W       = $clog2(DEF_TILES_ROW);
  localparam int unsigned SB_ROW_W       = $clog2(DEF_ROW_BLOCKS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [SB_COL_W-1:0] col;
    logic [SB_ROW_W-1:0] row;
    logic                last_col;
    logic                last_tile;
  } sideband_t;

endpackage

// File: rtl/rshift_ctrl_sideband_delay.sv
// Fixed-depth delay line that carries tile sideband plus a valid bit so it
// emerges in the same cycle as the rshift unit's out_valid.
module sideband_delay
  import attn_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic      clk,
  input  logic      rst,
  input  sideband_t in_sb,
  input  logic      in_valid,
  output sideband_t out_sb,
  output logic      out_valid
);

  sideband_t        sb_q  [DEPTH];
  logic [DEPTH-1:0] vld_q;

  // Shift sideband and valid one stage per clock; reset flushes every stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        sb_q[i]  <= '0;
        vld_q[i] <= 1'b0;
      end
    end else begin
      sb_q[0]  <= in_sb;
      vld_q[0] <= in_valid;
      for (int i = 1; i < DEPTH; i++) begin
        sb_q[i]  <= sb_q[i-1];
        vld_q[i] <= vld_q[i-1];
      end
    end
  end

  assign out_sb    = sb_q[DEPTH-1];
  assign out_valid = vld_q[DEPTH-1];

endmodule

// File: rtl/rshift_ctrl.sv
// Sequences one head pass of QK^T tiles into the rshift unit: credit-based
// flow control toward the softmax FIFO, tile position tracking, in-flight
// accounting and sideband alignment with the rshift output.
module rshift_ctrl
  import attn_ctrl_pkg::*;
#(
  parameter int unsigned NUM_TILES_ROW  = 4,
  parameter int unsigned NUM_ROW_BLOCKS = 2,
  parameter int unsigned RSHIFT_LATENCY = 1,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  output logic                              busy,
  output logic                              done,
  input  logic                              s_valid,
  output logic                              s_ready,
  output logic                              rs_in_valid,
  input  logic                              rs_out_valid,
  input  logic                              fifo_pop,
  output logic [$clog2(NUM_TILES_ROW)-1:0]  tile_col,
  output logic [$clog2(NUM_ROW_BLOCKS)-1:0] tile_row,
  output logic                              last_col,
  output logic                              last_tile,
  output logic                              err
);

  localparam int unsigned COL_W = $clog2(NUM_TILES_ROW);
  localparam int unsigned ROW_W = $clog2(NUM_ROW_BLOCKS);
  localparam int unsigned CRD_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned TOTAL = NUM_TILES_ROW * NUM_ROW_BLOCKS;
  localparam int unsigned INF_W = $clog2(TOTAL + 1);

  // The sideband struct fields are sized by the package defaults.
  if (COL_W != SB_COL_W || ROW_W != SB_ROW_W) begin : g_width_check
    $error("rshift_ctrl: tiling parameters do not fit attn_ctrl_pkg::sideband_t");
  end

  state_t           state;
  logic [CRD_W-1:0] credits;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [INF_W-1:0] inflight;
  logic [INF_W-1:0] inflight_next;
  logic             err_q;

  logic      ready_int;
  logic      issue;
  logic      col_last;
  logic      row_last;
  logic      pop_bad;
  logic      pop_ok;
  logic      mismatch;
  sideband_t sb_in;
  sideband_t sb_out;
  logic      dly_valid;
  logic      sb_live;

  assign ready_int = !rst && (state == ST_RUN) && (credits != '0);
  assign issue     = s_valid && ready_int;
  assign col_last  = (col == COL_W'(NUM_TILES_ROW - 1));
  assign row_last  = (row == ROW_W'(NUM_ROW_BLOCKS - 1));
  // A pop at full credit is only legal when an issue consumes a credit that cycle.
  assign pop_bad   = fifo_pop && (credits == CRD_W'(FIFO_DEPTH)) && !issue;
  assign pop_ok    = fifo_pop && !pop_bad;
  assign mismatch  = rs_out_valid != dly_valid;

  // Next in-flight count; a spurious rs_out_valid at zero does not underflow.
  always_comb begin
    inflight_next = inflight;
    if (issue && !rs_out_valid) begin
      inflight_next = inflight + INF_W'(1);
    end else if (!issue && rs_out_valid && (inflight != '0)) begin
      inflight_next = inflight - INF_W'(1);
    end
  end

  // Sideband captured at issue time.
  always_comb begin
    sb_in           = '0;
    sb_in.col       = col;
    sb_in.row       = row;
    sb_in.last_col  = col_last;
    sb_in.last_tile = col_last && row_last;
  end

  // Pass FSM with credits, tile counters, in-flight count and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      credits  <= '0;
      col      <= '0;
      row      <= '0;
      inflight <= '0;
      err_q    <= 1'b0;
    end else begin
      inflight <= inflight_next;

      if (issue && !pop_ok) begin
        credits <= credits - CRD_W'(1);
      end else if (!issue && pop_ok) begin
        credits <= credits + CRD_W'(1);
      end

      if (issue) begin
        if (col_last) begin
          col <= '0;
          row <= row_last ? '0 : row + ROW_W'(1);
        end else begin
          col <= col + COL_W'(1);
        end
      end

      if (pop_bad || mismatch) begin
        err_q <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_RUN;
            credits <= CRD_W'(FIFO_DEPTH);
            col     <= '0;
            row     <= '0;
            err_q   <= 1'b0;
          end
        end
        ST_RUN: begin
          if (issue && col_last && row_last) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (inflight_next == '0) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  sideband_delay #(
    .DEPTH(RSHIFT_LATENCY)
  ) u_sideband_delay (
    .clk      (clk),
    .rst      (rst),
    .in_sb    (sb_in),
    .in_valid (issue),
    .out_sb   (sb_out),
    .out_valid(dly_valid)
  );

  assign sb_live     = dly_valid && !rst;
  assign s_ready     = ready_int;
  assign rs_in_valid = issue;
  assign busy        = !rst && (state != ST_IDLE);
  assign done        = !rst && (state == ST_DONE);
  assign err         = !rst && err_q;
  assign tile_col    = sb_live ? sb_out.col : '0;
  assign tile_row    = sb_live ? sb_out.row : '0;
  assign last_col    = sb_live && sb_out.last_col;
  assign last_tile   = sb_live && sb_out.last_tile;

endmodule

// File: tb/tb_rshift_ctrl.sv
// Directed bench for rshift_ctrl: one instance at default latency, one with
// a three-cycle rshift; each has a small rshift valid pipe model.
module tb_rshift_ctrl;

  logic       clk;
  logic       rst;
  logic       start, s_valid, fifo_pop, inject;
  logic       busy, done, s_ready, rs_in_valid, rs_out_valid;
  logic       last_col, last_tile, err;
  logic [1:0] tile_col;
  logic [0:0] tile_row;
  logic       rs_pipe;

  logic       start3, s_valid3, fifo_pop3;
  logic       busy3, done3, s_ready3, rs_in_valid3, rs_out_valid3;
  logic       last_col3, last_tile3, err3;
  logic [1:0] tile_col3;
  logic [0:0] tile_row3;
  logic [2:0] rs_pipe3;

  int n_cmp;
  int n_err;

  rshift_ctrl u_dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .s_valid(s_valid), .s_ready(s_ready), .rs_in_valid(rs_in_valid),
    .rs_out_valid(rs_out_valid), .fifo_pop(fifo_pop),
    .tile_col(tile_col), .tile_row(tile_row), .last_col(last_col),
    .last_tile(last_tile), .err(err)
  );

  rshift_ctrl #(.RSHIFT_LATENCY(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .busy(busy3), .done(done3),
    .s_valid(s_valid3), .s_ready(s_ready3), .rs_in_valid(rs_in_valid3),
    .rs_out_valid(rs_out_valid3), .fifo_pop(fifo_pop3),
    .tile_col(tile_col3), .tile_row(tile_row3), .last_col(last_col3),
    .last_tile(last_tile3), .err(err3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // rshift models: fixed-latency valid pipes, flushed by reset.
  always @(posedge clk) begin
    if (rst) begin
      rs_pipe  <= 1'b0;
      rs_pipe3 <= 3'b000;
    end else begin
      rs_pipe  <= rs_in_valid;
      rs_pipe3 <= {rs_pipe3[1:0], rs_in_valid3};
    end
  end
  assign rs_out_valid  = rs_pipe | inject;
  assign rs_out_valid3 = rs_pipe3[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] outs1();
    return 32'({busy, done, s_ready, rs_in_valid, last_col, last_tile, err, tile_col, tile_row});
  endfunction

  function automatic logic [31:0] outs3();
    return 32'({busy3, done3, s_ready3, rs_in_valid3, last_col3, last_tile3, err3, tile_col3, tile_row3});
  endfunction

  task automatic cyc(input logic sv, input logic pop);
    @(negedge clk);
    start    = 1'b0;
    s_valid  = sv;
    fifo_pop = pop;
    #1;
  endtask

  task automatic do_start();
    @(negedge clk);
    start    = 1'b1;
    s_valid  = 1'b0;
    fifo_pop = 1'b0;
    #1;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1; start = 1'b0; s_valid = 1'b0; fifo_pop = 1'b0; inject = 1'b0;
    #1;
    chk({tag, "_during"}, outs1(), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk({tag, "_after"}, outs1(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    n_cmp = 0; n_err = 0;
    rst = 1'b1; start = 1'b0; s_valid = 1'b0; fifo_pop = 1'b0; inject = 1'b0;
    start3 = 1'b0; s_valid3 = 1'b0; fifo_pop3 = 1'b0;

    // Reset state
    @(negedge clk); #1;
    chk("reset_outs", outs1(), 32'd0);
    chk("reset_outs3", outs3(), 32'd0);
    @(negedge clk); rst = 1'b0; #1;
    chk("post_reset_outs", outs1(), 32'd0);

    // Full pass, pop with every issue; a start mid-pass must be ignored
    do_start();
    chk("p1_start_ready", 32'(s_ready), 32'd0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      start = (k == 2); s_valid = 1'b1; fifo_pop = 1'b1;
      #1;
      chk($sformatf("p1_ready_%0d", k), 32'(s_ready), 32'd1);
      chk($sformatf("p1_issue_%0d", k), 32'(rs_in_valid), 32'd1);
      chk($sformatf("p1_busy_%0d", k), 32'(busy), 32'd1);
      if (k > 0) begin
        chk($sformatf("p1_col_%0d", k), 32'(tile_col), 32'((k - 1) % 4));
        chk($sformatf("p1_row_%0d", k), 32'(tile_row), 32'((k - 1) / 4));
        chk($sformatf("p1_lastcol_%0d", k), 32'(last_col), 32'((k - 1) % 4 == 3));
        chk($sformatf("p1_lasttile_%0d", k), 32'(last_tile), 32'd0);
      end
    end
    cyc(1'b0, 1'b0);
    chk("p1_drain_issue", 32'(rs_in_valid), 32'd0);
    chk("p1_t7_col", 32'(tile_col), 32'd3);
    chk("p1_t7_row", 32'(tile_row), 32'd1);
    chk("p1_t7_lastcol", 32'(last_col), 32'd1);
    chk("p1_t7_lasttile", 32'(last_tile), 32'd1);
    chk("p1_drain_done", 32'(done), 32'd0);
    cyc(1'b0, 1'b0);
    chk("p1_done", 32'(done), 32'd1);
    chk("p1_done_busy", 32'(busy), 32'd1);
    chk("p1_done_lasttile", 32'(last_tile), 32'd0);
    cyc(1'b0, 1'b0);
    chk("p1_idle_done", 32'(done), 32'd0);
    chk("p1_idle_busy", 32'(busy), 32'd0);
    chk("p1_err", 32'(err), 32'd0);

    // Credit exhaustion: four issues, stall, one pop buys one more issue
    do_start();
    for (int k = 0; k < 9; k++) begin
      cyc(1'b1, k == 6);
      chk($sformatf("p2_ready_%0d", k), 32'(s_ready), 32'((k < 4) || (k == 7)));
      chk($sformatf("p2_issue_%0d", k), 32'(rs_in_valid), 32'((k < 4) || (k == 7)));
      if (k == 4) begin
        chk("p2_t3_col", 32'(tile_col), 32'd3);
        chk("p2_t3_lastcol", 32'(last_col), 32'd1);
        chk("p2_t3_lasttile", 32'(last_tile), 32'd0);
      end
    end

    // Mid-pass reset after five issues, then restart from tile 0
    do_reset("p3_rst");
    do_start();
    cyc(1'b1, 1'b1);
    chk("p3_ready", 32'(s_ready), 32'd1);
    cyc(1'b1, 1'b1);
    chk("p3_col0", 32'(tile_col), 32'd0);
    chk("p3_row0", 32'(tile_row), 32'd0);
    chk("p3_lastcol0", 32'(last_col), 32'd0);
    cyc(1'b0, 1'b0);
    chk("p3_col1", 32'(tile_col), 32'd1);
    chk("p3_row1", 32'(tile_row), 32'd0);
    do_reset("p3_rst2");

    // Pop and issue together at one credit keeps the credit
    do_start();
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 1'b0);
      chk($sformatf("p4_ready_%0d", k), 32'(s_ready), 32'd1);
    end
    cyc(1'b1, 1'b1);
    chk("p4_both_ready", 32'(s_ready), 32'd1);
    chk("p4_both_issue", 32'(rs_in_valid), 32'd1);
    cyc(1'b0, 1'b0);
    chk("p4_after_ready", 32'(s_ready), 32'd1);
    cyc(1'b1, 1'b0);
    chk("p4_last_issue", 32'(rs_in_valid), 32'd1);
    cyc(1'b0, 1'b0);
    chk("p4_empty_ready", 32'(s_ready), 32'd0);
    chk("p4_err", 32'(err), 32'd0);
    do_reset("p4_rst");

    // Spurious rs_out_valid with nothing in flight; sticky until start
    @(negedge clk); inject = 1'b1; #1;
    chk("p5_err_pre", 32'(err), 32'd0);
    @(negedge clk); inject = 1'b0; #1;
    chk("p5_err_set", 32'(err), 32'd1);
    repeat (3) cyc(1'b0, 1'b0);
    chk("p5_err_hold", 32'(err), 32'd1);
    do_start();
    chk("p5_err_at_start", 32'(err), 32'd1);
    cyc(1'b0, 1'b0);
    chk("p5_err_cleared", 32'(err), 32'd0);
    // Pop at full credit with no issue
    cyc(1'b0, 1'b1);
    chk("p5_pop_err_pre", 32'(err), 32'd0);
    cyc(1'b0, 1'b0);
    chk("p5_pop_err", 32'(err), 32'd1);
    do_reset("p5_rst");

    // Three-cycle rshift: sideband appears exactly with rs_out_valid
    @(negedge clk); start3 = 1'b1; #1;
    for (int c = 0; c < 14; c++) begin
      int t;
      logic v;
      @(negedge clk);
      start3 = 1'b0; s_valid3 = (c < 8); fifo_pop3 = (c < 8);
      #1;
      t = c - 3;
      v = (c >= 3) && (c <= 10);
      chk($sformatf("l3_ready_%0d", c), 32'(s_ready3), 32'(c < 8));
      chk($sformatf("l3_col_%0d", c), 32'(tile_col3), v ? 32'(t % 4) : 32'd0);
      chk($sformatf("l3_row_%0d", c), 32'(tile_row3), v ? 32'(t / 4) : 32'd0);
      chk($sformatf("l3_lastcol_%0d", c), 32'(last_col3), 32'(v && (t % 4 == 3)));
      chk($sformatf("l3_lasttile_%0d", c), 32'(last_tile3), 32'(v && (t == 7)));
      chk($sformatf("l3_done_%0d", c), 32'(done3), 32'(c == 11));
      chk($sformatf("l3_err_%0d", c), 32'(err3), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
